shift_iter_unit: RTL

Multi-cycle 32-bit right shifter/rotator that sequences the logarithmic shift stages (distances 1, 2, 4, 8, 16) over successive clock cycles, one stage per cycle. It accepts an operand and shift amount through a valid/ready handshake and holds the result until the consumer takes it. It sits directly upstream of the per-stage shift muxes: it supplies each stage's data, fill bit, rotate select and enable, and registers the stage output.

---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_stage.sv | 33 +++
 rtl/shift_iter_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// shift_pkg
// Shared definitions for the iterative right shifter/rotator.
//   WIDTH       : operand width (power of two)
//   SHW         : shift-amount width, also the number of shift stages
//   KW          : width of the stage counter that indexes the SHW stages
//   state_t     : control FSM states
//   SEL_FILL    : stage upper bits come from the replicated fill bit
//   SEL_ROTATE  : stage upper bits come from the low data bits (rotate)
package shift_pkg;

    localparam int WIDTH = 32;
    localparam int SHW   = $clog2(WIDTH);
    localparam int KW    = $clog2(SHW);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic SEL_FILL   = 1'b0;
    localparam logic SEL_ROTATE = 1'b1;

endpackage

// File: rtl/shift_stage.sv
// shift_stage
// One logarithmic right-shift stage of fixed distance DIST. It is purely
// combinational. When the enable is low the data passes through unchanged.
// Ports:
//   data     in  WIDTH : stage input data
//   fill_bit in  1     : bit replicated into the vacated upper bits
//   rot_sel  in  1     : SEL_ROTATE wraps the low DIST bits to the top
//   enable   in  1     : apply this stage's shift
//   result   out WIDTH : stage output
module shift_stage
    import shift_pkg::*;
#(
    parameter int DIST = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             fill_bit,
    input  logic             rot_sel,
    input  logic             enable,
    output logic [WIDTH-1:0] result
);

    logic [DIST-1:0] upper;

    always_comb begin
        upper = (rot_sel == SEL_ROTATE) ? data[DIST-1:0] : {DIST{fill_bit}};
        if (enable) begin
            result = {upper, data[WIDTH-1:DIST]};
        end else begin
            result = data;
        end
    end

endmodule

// File: rtl/shift_iter_unit.sv
// shift_iter_unit
// Multi-cycle 32-bit right shifter/rotator. One logarithmic stage
// (distance 1, 2, 4, 8, 16) is applied per clock. The latency is fixed and
// does not depend on the shift amount.
// Ports:
//   clk       in  1     : clock, rising edge
//   rst_n     in  1     : asynchronous active-low reset
//   in_valid  in  1     : request present
//   in_ready  out 1     : request can be accepted (IDLE only)
//   in_data   in  WIDTH : operand
//   in_amt    in  SHW   : shift distance
//   in_sra    in  1     : arithmetic shift (fill with operand MSB)
//   in_rotate in  1     : rotate right, takes priority over in_sra
//   out_valid out 1     : result present
//   out_ready in  1     : consumer takes the result
//   out_data  out WIDTH : result (the data register)
//   busy      out 1     : operation in progress or result held
module shift_iter_unit
    import shift_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_sra,
    input  logic             in_rotate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   amt_q;
    logic             rot_q;
    logic             fill_q;
    logic [KW-1:0]    k_q;

    logic [WIDTH-1:0] stage_out [SHW];
    logic [WIDTH-1:0] stage_sel;

    // One stage instance per distance 2^g. Each stage sees the current data
    // register, and its enable is the matching bit of the captured amount.
    for (genvar g = 0; g < SHW; g++) begin : g_stage
        shift_stage #(
            .DIST(1 << g)
        ) u_stage (
            .data     (data_q),
            .fill_bit (fill_q),
            .rot_sel  (rot_q),
            .enable   (amt_q[g]),
            .result   (stage_out[g])
        );
    end

    assign stage_sel = stage_out[k_q];
    assign out_data  = data_q;

    // The handshake outputs are registered alongside the state, so no input
    // reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            data_q    <= '0;
            amt_q     <= '0;
            rot_q     <= SEL_FILL;
            fill_q    <= 1'b0;
            k_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        amt_q    <= in_amt;
                        rot_q    <= in_rotate ? SEL_ROTATE : SEL_FILL;
                        // The fill bit is taken from the original operand and
                        // never from intermediate shifted data.
                        fill_q   <= in_sra & in_data[WIDTH-1];
                        k_q      <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    // A disabled stage passes data through, so the register
                    // is written on every stage edge.
                    data_q <= stage_sel;
                    if (k_q == KW'(SHW - 1)) begin
                        // Hold k on the last stage so it never indexes past
                        // the final stage.
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
